// File: rtl/instr_encoder_if.sv
// Field-bundle and memory-write bus for the instruction encoder.
// The master side feeds instructions and answers memory writes; the slave side is the encoder.
interface instr_encoder_if;
  logic        start;
  logic [15:0] base;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [2:0]  dest;
  logic [2:0]  src1;
  logic [2:0]  src2;
  logic [10:0] imm;
  logic [2:0]  fmt;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  logic [15:0] count;
  logic        wrapped;

  modport master (
    output start, base, in_valid, opcode, dest, src1, src2, imm, fmt, mem_resp,
    input  in_ready, mem_address, mem_wdata, mem_write, mem_byte_enable, count, wrapped
  );

  modport slave (
    input  start, base, in_valid, opcode, dest, src1, src2, imm, fmt, mem_resp,
    output in_ready, mem_address, mem_wdata, mem_write, mem_byte_enable, count, wrapped
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs instruction fields into 16-bit words and writes them to consecutive
// halfword addresses, one word per memory handshake.
module instr_encoder (
  input logic            clk,
  input logic            reset_n,
  instr_encoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READY, WRITE} state_t;

  state_t      state_reg, state_next;
  logic [15:0] addr_reg, addr_next;
  logic [15:0] wdata_reg, wdata_next;
  logic [15:0] count_reg, count_next;
  logic        wrapped_reg, wrapped_next;
  logic [15:0] enc_word;
  logic        accept;

  function automatic logic [15:0] encode(
    input logic [3:0]  opcode,
    input logic [2:0]  dest,
    input logic [2:0]  src1,
    input logic [2:0]  src2,
    input logic [10:0] imm,
    input logic [2:0]  fmt
  );
    logic [15:0] w;
    w = 16'h0000;
    case (fmt)
      3'd1:    w = {opcode, dest, src1, 1'b1, imm[4:0]};
      3'd2:    w = {opcode, dest, src1, imm[5:0]};
      3'd3:    w = {opcode, dest, imm[8:0]};
      3'd4:    w = {opcode, 1'b1, imm[10:0]};
      3'd5:    w = {opcode, 4'b0000, imm[7:0]};
      3'd6:    w = {opcode, 3'b000, src1, 6'b000000};
      default: w = {opcode, dest, src1, 3'b000, src2};
    endcase
    return w;
  endfunction

  always_comb begin
    enc_word = encode(bus.opcode, bus.dest, bus.src1, bus.src2, bus.imm, bus.fmt);
  end

  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      addr_reg    <= 16'h0000;
      wdata_reg   <= 16'h0000;
      count_reg   <= 16'h0000;
      wrapped_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      count_reg   <= count_next;
      wrapped_reg <= wrapped_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    count_next   = count_reg;
    wrapped_next = wrapped_reg;
    case (state_reg)
      IDLE, READY: begin
        if (bus.start) begin
          state_next   = READY;
          addr_next    = bus.base & 16'hFFFE;
          count_next   = 16'h0000;
          wrapped_next = 1'b0;
        end else if (accept) begin
          state_next = WRITE;
          wdata_next = enc_word;
        end
      end
      WRITE: begin
        // start is deliberately not looked at here; the write in flight finishes first
        if (bus.mem_resp) begin
          state_next = READY;
          addr_next  = addr_reg + 16'd2;
          if (count_reg != 16'hFFFF) begin
            count_next = count_reg + 16'd1;
          end
          if (addr_reg == 16'hFFFE) begin
            wrapped_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    // a start pulse in READY wins over in_valid, so ready drops for that cycle
    bus.in_ready        = (state_reg == READY) && !bus.start;
    bus.mem_write       = (state_reg == WRITE);
    bus.mem_byte_enable = (state_reg == WRITE) ? 2'b11 : 2'b00;
    bus.mem_address     = addr_reg;
    bus.mem_wdata       = wdata_reg;
    bus.count           = count_reg;
    bus.wrapped         = wrapped_reg;
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Checks instr_encoder with a fixed vector table, hand-built corner sequences
// and random instructions compared against an arithmetic reference model.
module tb_instr_encoder;
  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  logic [15:0] m_addr;
  logic [15:0] m_count;
  logic        m_wrap;

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  d;
    logic [2:0]  s1;
    logic [2:0]  s2;
    logic [10:0] imm;
    logic [2:0]  fmt;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];

  instr_encoder_if bus ();

  instr_encoder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference encoding built from field weights rather than bit slicing.
  function automatic logic [15:0] model_word(input int op, input int d, input int s1,
                                             input int s2, input int imm, input int fmt);
    int w;
    w = op * 4096;
    case (fmt)
      1:       w += d * 512 + s1 * 64 + 32 + (imm % 32);
      2:       w += d * 512 + s1 * 64 + (imm % 64);
      3:       w += d * 512 + (imm % 512);
      4:       w += 2048 + (imm % 2048);
      5:       w += imm % 256;
      6:       w += s1 * 64;
      default: w += d * 512 + s1 * 64 + s2;
    endcase
    return w[15:0];
  endfunction

  task automatic model_complete();
    if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
    if (m_addr == 16'hFFFE) m_wrap = 1'b1;
    m_addr = m_addr + 16'd2;
  endtask

  task automatic drive_fields(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s1,
                              input logic [2:0] s2, input logic [10:0] imm, input logic [2:0] fmt);
    bus.opcode = op;
    bus.dest   = d;
    bus.src1   = s1;
    bus.src2   = s2;
    bus.imm    = imm;
    bus.fmt    = fmt;
  endtask

  // Called at a negedge with the DUT in READY.
  task automatic do_start(input logic [15:0] b);
    bus.start = 1'b1;
    bus.base  = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.base  = 16'h5A5A;
    m_addr  = b & 16'hFFFE;
    m_count = 16'h0000;
    m_wrap  = 1'b0;
    @(negedge clk);
    check("start_addr", bus.mem_address, m_addr);
    check("start_count", bus.count, m_count);
  endtask

  // Called at a negedge with the DUT in READY; returns at a negedge back in READY.
  task automatic do_write(input string name, input logic [3:0] op, input logic [2:0] d,
                          input logic [2:0] s1, input logic [2:0] s2, input logic [10:0] imm,
                          input logic [2:0] fmt, input logic [15:0] exp, input int delay);
    check({name, "_ready"}, bus.in_ready, 1'b1);
    drive_fields(op, d, s1, s2, imm, fmt);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({name, "_wr"}, bus.mem_write, 1'b1);
    check({name, "_be"}, bus.mem_byte_enable, 2'b11);
    check({name, "_addr"}, bus.mem_address, m_addr);
    check({name, "_data"}, bus.mem_wdata, exp);
    for (int k = 0; k < delay; k++) begin
      bus.in_valid = 1'b1;
      drive_fields(4'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                   11'($urandom), 3'($urandom));
      @(negedge clk);
      check({name, "_ws_data"}, bus.mem_wdata, exp);
      check({name, "_ws_addr"}, bus.mem_address, m_addr);
      check({name, "_ws_rdy"}, {bus.in_ready, bus.mem_write}, 2'b01);
    end
    bus.in_valid = 1'b0;
    bus.mem_resp = 1'b1;
    @(negedge clk);
    bus.mem_resp = 1'b0;
    model_complete();
    check({name, "_count"}, bus.count, m_count);
    check({name, "_wrap"}, bus.wrapped, m_wrap);
    check({name, "_next"}, bus.mem_address, m_addr);
    check({name, "_done"}, {bus.in_ready, bus.mem_write}, 2'b10);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_addr   = 16'h0000;
    m_count  = 16'h0000;
    m_wrap   = 1'b0;
    reset_n  = 1'b0;
    bus.start    = 1'b0;
    bus.base     = 16'h0000;
    bus.in_valid = 1'b0;
    bus.mem_resp = 1'b0;
    drive_fields(4'd0, 3'd0, 3'd0, 3'd0, 11'd0, 3'd0);

    vecs[0] = '{4'd1,  3'd2, 3'd3, 3'd4, 11'h000, 3'd0, 16'h14C4};
    vecs[1] = '{4'd1,  3'd1, 3'd1, 3'd0, 11'h01B, 3'd1, 16'h127B};
    vecs[2] = '{4'd0,  3'd7, 3'd0, 3'd0, 11'h1FF, 3'd3, 16'h0FFF};
    vecs[3] = '{4'd4,  3'd5, 3'd0, 3'd0, 11'h400, 3'd4, 16'h4C00};
    vecs[4] = '{4'd15, 3'd7, 3'd7, 3'd0, 11'h725, 3'd5, 16'hF025};
    vecs[5] = '{4'd12, 3'd3, 3'd7, 3'd0, 11'h7FF, 3'd6, 16'hC1C0};
    vecs[6] = '{4'd6,  3'd3, 3'd2, 3'd0, 11'h7E5, 3'd2, 16'h66A5};
    vecs[7] = '{4'd5,  3'd1, 3'd2, 3'd3, 11'h7FF, 3'd7, 16'h5283};

    // Reset state, then idle with no start: nothing may be accepted.
    repeat (2) @(negedge clk);
    check("rst_outs", {bus.in_ready, bus.mem_write, bus.mem_byte_enable}, 4'b0000);
    check("rst_addr", bus.mem_address, 16'h0000);
    check("rst_data", bus.mem_wdata, 16'h0000);
    check("rst_cnt", {bus.count, 15'd0, bus.wrapped}, 32'h0);
    reset_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.mem_resp = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_hold", {bus.in_ready, bus.mem_write, bus.count}, 18'h0);
    bus.in_valid = 1'b0;
    bus.mem_resp = 1'b0;

    // Fixed vectors, including the 5-cycle wait-state case.
    do_start(16'h0100);
    for (int i = 0; i < 8; i++) begin
      do_write($sformatf("vec%0d", i), vecs[i].op, vecs[i].d, vecs[i].s1, vecs[i].s2,
               vecs[i].imm, vecs[i].fmt, vecs[i].exp, (i == 1) ? 5 : 0);
    end

    // mem_resp outside WRITE has no effect.
    bus.mem_resp = 1'b1;
    @(negedge clk);
    bus.mem_resp = 1'b0;
    check("stray_resp_cnt", bus.count, m_count);
    check("stray_resp_addr", bus.mem_address, m_addr);

    // start during WRITE is ignored.
    drive_fields(4'd3, 3'd1, 3'd2, 3'd0, 11'h015, 3'd2);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.start = 1'b1;
    bus.base  = 16'h4000;
    @(negedge clk);
    bus.start = 1'b0;
    check("wstart_addr", bus.mem_address, m_addr);
    bus.mem_resp = 1'b1;
    @(negedge clk);
    bus.mem_resp = 1'b0;
    model_complete();
    check("wstart_after", bus.mem_address, m_addr);
    check("wstart_cnt", bus.count, m_count);

    // Start in READY reloads base and clears count.
    do_start(16'h0203);
    check("reload_state", bus.in_ready, 1'b1);

    // Address wrap and sticky flag.
    do_start(16'hFFFF);
    do_write("wrap0", 4'd2, 3'd1, 3'd0, 3'd0, 11'h003, 3'd3, 16'h2203, 0);
    check("wrap_set", bus.wrapped, 1'b1);
    do_write("wrap1", 4'd2, 3'd1, 3'd0, 3'd0, 11'h004, 3'd3, 16'h2204, 1);
    check("wrap_addr1", bus.mem_address, 16'h0002);
    do_start(16'h0000);
    check("wrap_clear", bus.wrapped, 1'b0);

    // Random instructions against the reference model.
    for (int i = 0; i < 40; i++) begin
      int op, d, s1, s2, imm, fmt;
      if (i % 13 == 5) do_start(($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'hFFF9);
      op  = $urandom_range(0, 15);
      d   = $urandom_range(0, 7);
      s1  = $urandom_range(0, 7);
      s2  = $urandom_range(0, 7);
      imm = $urandom_range(0, 2047);
      fmt = $urandom_range(0, 7);
      do_write($sformatf("rnd%0d", i), 4'(op), 3'(d), 3'(s1), 3'(s2), 11'(imm), 3'(fmt),
               model_word(op, d, s1, s2, imm, fmt), $urandom_range(0, 2));
    end

    // Reset in the middle of a write aborts it at once.
    drive_fields(4'd9, 3'd4, 3'd5, 3'd6, 11'h000, 3'd0);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("mrst_pre", bus.mem_write, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("mrst_wr", {bus.mem_write, bus.in_ready, bus.mem_byte_enable}, 4'b0000);
    check("mrst_addr", bus.mem_address, 16'h0000);
    check("mrst_cnt", {bus.count, 15'd0, bus.wrapped}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.mem_resp = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("mrst_idle", {bus.mem_write, bus.in_ready, bus.count}, 18'h0);
    end
    bus.in_valid = 1'b0;
    bus.mem_resp = 1'b0;
    do_start(16'h0300);
    do_write("post_rst", 4'd1, 3'd2, 3'd3, 3'd4, 11'h000, 3'd0, 16'h14C4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have ports: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: start  input  1  one-cycle pulse; loads base and clears count.
REQ-004 SHALL have ports: base  input  16  first write address; bit 0 is ignored.
REQ-005 SHALL have ports: in_valid  input  1 / in_ready  output  1  field-bundle handshake.
REQ-006 SHALL have ports: opcode  input  4 / dest, src1, src2  input  3 each / imm  input  11 / fmt  input  3  instruction fields.
REQ-007 SHALL have ports: mem_address  output  16 / mem_wdata  output  16 / mem_write  output  1 / mem_byte_enable  output  2 / mem_resp  input  1  memory write port.
REQ-008 SHALL have ports: count  output  16  words written since start / wrapped  output  1  sticky address-wrap flag.

Function
REQ-009 SHALL encode the word as: [15:12]=opcode, [11:9]=dest, and bits [8:0] according to fmt.
REQ-010 fmt=0 (REG) SHALL place src1 at [8:6], 000 at [5:3] and src2 at [2:0].
REQ-011 fmt=1 (IMM5) SHALL place src1 at [8:6], 1 at [5] and imm[4:0] at [4:0].
REQ-012 fmt=2 (OFF6/SHF) SHALL place src1 at [8:6] and imm[5:0] at [5:0].
REQ-013 fmt=3 (OFF9) SHALL place imm[8:0] at [8:0].
REQ-014 fmt=4 (OFF11) SHALL override [11] with 1 and place imm[10:0] at [10:0].
REQ-015 fmt=5 (TRAP) SHALL place 0000 at [11:8] and imm[7:0] at [7:0].
REQ-016 fmt=6 (BASE, JMP/JSRR) SHALL place 000 at [11:9], src1 at [8:6] and 000000 at [5:0].
REQ-017 fmt=7 (REG) SHALL encode identically to fmt=0.
REQ-018 SHALL ignore imm bits not used by the selected fmt.
REQ-019 SHALL implement FSM states IDLE, READY, WRITE.
REQ-020 IDLE SHALL hold in_ready=0 and mem_write=0; start SHALL cause IDLE->READY, load addr=base&16'hFFFE, count=0 and wrapped=0.
REQ-021 READY SHALL drive in_ready=1; when in_valid=1, the encoded word SHALL be registered into mem_wdata and the FSM SHALL go to WRITE on the next edge.
REQ-022 WRITE SHALL drive mem_write=1, mem_byte_enable=2'b11, in_ready=0, and hold mem_address and mem_wdata stable until mem_resp.
REQ-023 On mem_resp in WRITE, the block SHALL increment addr by 2, increment count and return to READY; the earliest next acceptance is the cycle after.
REQ-024 Accept-to-mem_write latency SHALL be 1 cycle, giving a maximum throughput of 1 word per 2 cycles at zero-wait memory.
REQ-025 An address increment from 16'hFFFE SHALL wrap to 16'h0000 and set wrapped=1; wrapped SHALL stay set until start or reset.
REQ-026 count SHALL saturate at 16'hFFFF.
REQ-027 A start pulse in READY SHALL reload base, clear count and wrapped, and remain in READY.
REQ-028 A start pulse in WRITE SHALL be ignored.
REQ-029 mem_resp outside WRITE SHALL be ignored.
REQ-030 Inputs SHALL be sampled only on an in_valid&in_ready cycle; field changes at any other time SHALL have no effect.

Reset
REQ-031 While reset_n=0, asynchronously: state=IDLE, in_ready=0, mem_write=0, mem_byte_enable=0, mem_address=0, mem_wdata=0, count=0, wrapped=0.
REQ-032 Reset asserted in WRITE SHALL abort the write immediately (mem_write=0); no resume SHALL occur after release.
REQ-033 After release, the block SHALL stay in IDLE until start.

Verification
REQ-034 ADD reg: start base=16'h0100, then opcode=1, dest=2, src1=3, src2=4, fmt=0 -> mem_wdata=16'h14C4 at 16'h0100; after mem_resp, count=1.
REQ-035 Every fmt: ADD imm -5 (fmt=1, dest=1, src1=1, imm=11'h01B) -> 16'h127B; BR nzp (opcode=0, dest=7, fmt=3, imm=9'h1FF) -> 16'h0FFF; JSR (opcode=4, fmt=4, imm=11'h400) -> 16'h4C00; TRAP (opcode=15, fmt=5, imm=8'h25) -> 16'hF025; JMP (opcode=12, src1=7, fmt=6) -> 16'hC1C0.
REQ-036 Wait states: mem_resp delayed 5 cycles -> mem_address and mem_wdata stable, in_ready=0 throughout, and in_valid with changing fields ignored.
REQ-037 Wrap: base=16'hFFFF, write 2 words -> addresses 16'hFFFE then 16'h0000; wrapped=1 after the first mem_resp; a following start clears it.
REQ-038 Mid-write reset: assert reset_n=0 during WRITE -> mem_write=0 in the same cycle; after release, IDLE with count=0 and no write until start.
